mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 21 ++
 rtl/mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Memory-side bus between the arbiter and a word-addressed memory.
// The master modport faces the arbiter; the slave modport faces the memory.
interface mem_arbiter_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch (IF) and data access (MA) onto one memory port,
// with byte-lane steering, load extension, misalignment errors and a bus timeout.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        stall_IF,
  input  logic [1:0]  wrn_MA,
  input  logic [2:0]  num_bytes_MA,
  input  logic        signado_MA,
  input  logic [31:0] addr_MA,
  input  logic [31:0] wdata_MA,
  output logic [31:0] rdata_MA,
  output logic        done_MA,
  output logic        err_MA,
  output logic        stall_MA,
  mem_arbiter_if.master mem,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MA} state_t;

  localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

  state_t      state, state_next;
  logic        ma_rd, ma_wr, ma_pend, if_pend;
  logic        grant_ma, grant_if, ma_legal, finish, timeout;
  logic        last_ma;
  logic [9:0]  cnt;
  logic [1:0]  lat_lo;
  logic [2:0]  lat_size;
  logic        lat_signed, lat_we;
  logic [3:0]  be_ma;
  logic [31:0] wdata_rep, load_data;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic        unused_if_lo;

  assign unused_if_lo = &if_addr[1:0];
  assign ma_rd    = (wrn_MA == 2'b01);
  assign ma_wr    = (wrn_MA == 2'b10);
  assign stall_IF = if_req & ~if_valid;
  assign stall_MA = (ma_rd | ma_wr) & ~done_MA;

  always_comb begin
    ma_pend  = (ma_rd | ma_wr) & ~done_MA;
    if_pend  = if_req & ~if_valid;
    grant_ma = 1'b0;
    grant_if = 1'b0;
    if (state == IDLE) begin
      grant_ma = ma_pend & (~if_pend | ~last_ma);
      grant_if = if_pend & ~grant_ma;
    end

    case (num_bytes_MA)
      3'd0:    ma_legal = 1'b1;
      3'd2:    ma_legal = ~addr_MA[0];
      3'd4:    ma_legal = (addr_MA[1:0] == 2'b00);
      default: ma_legal = 1'b0;
    endcase

    case (num_bytes_MA)
      3'd0: begin
        be_ma     = 4'b0001 << addr_MA[1:0];
        wdata_rep = {4{wdata_MA[7:0]}};
      end
      3'd2: begin
        be_ma     = addr_MA[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_MA[15:0]}};
      end
      default: begin
        be_ma     = 4'b1111;
        wdata_rep = wdata_MA;
      end
    endcase

    // Ack wins over a timeout landing on the same cycle.
    finish  = (state != IDLE) & mem.mem_req & mem.mem_ack;
    timeout = (state != IDLE) & mem.mem_req & ~mem.mem_ack & (cnt == TO_LAST);

    state_next = state;
    case (state)
      IDLE: begin
        if (grant_ma && ma_legal) state_next = BUSY_MA;
        else if (grant_if)        state_next = BUSY_IF;
      end
      default: if (finish || timeout) state_next = IDLE;
    endcase
  end

  always_comb begin
    case (lat_lo)
      2'd0:    lb = mem.mem_rdata[7:0];
      2'd1:    lb = mem.mem_rdata[15:8];
      2'd2:    lb = mem.mem_rdata[23:16];
      default: lb = mem.mem_rdata[31:24];
    endcase
    lh = lat_lo[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (lat_size)
      3'd0:    load_data = lat_signed ? {{24{lb[7]}}, lb} : {24'd0, lb};
      3'd2:    load_data = lat_signed ? {{16{lh[15]}}, lh} : {16'd0, lh};
      default: load_data = mem.mem_rdata;
    endcase
    if (lat_we) load_data = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_ma       <= 1'b0;
      cnt           <= '0;
      lat_lo        <= '0;
      lat_size      <= '0;
      lat_signed    <= 1'b0;
      lat_we        <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_be    <= '0;
      mem.mem_wdata <= '0;
      if_rdata      <= '0;
      if_valid      <= 1'b0;
      rdata_MA      <= '0;
      done_MA       <= 1'b0;
      err_MA        <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      done_MA  <= 1'b0;
      err_MA   <= 1'b0;
      bus_err  <= 1'b0;
      if (state == IDLE) begin
        if (grant_ma) begin
          last_ma <= 1'b1;
          if (ma_legal) begin
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= ma_wr;
            mem.mem_addr  <= {addr_MA[31:2], 2'b00};
            mem.mem_be    <= be_ma;
            mem.mem_wdata <= wdata_rep;
            lat_lo        <= addr_MA[1:0];
            lat_size      <= num_bytes_MA;
            lat_signed    <= signado_MA;
            lat_we        <= ma_wr;
            cnt           <= '0;
          end else begin
            done_MA  <= 1'b1;
            err_MA   <= 1'b1;
            rdata_MA <= '0;
          end
        end else if (grant_if) begin
          last_ma       <= 1'b0;
          mem.mem_req   <= 1'b1;
          mem.mem_we    <= 1'b0;
          mem.mem_addr  <= {if_addr[31:2], 2'b00};
          mem.mem_be    <= 4'b1111;
          mem.mem_wdata <= '0;
          cnt           <= '0;
        end
      end else if (finish || timeout) begin
        mem.mem_req <= 1'b0;
        bus_err     <= timeout;
        if (state == BUSY_IF) begin
          if_valid <= 1'b1;
          if_rdata <= timeout ? '0 : mem.mem_rdata;
        end else begin
          done_MA  <= 1'b1;
          rdata_MA <= timeout ? '0 : load_data;
        end
      end else begin
        cnt <= cnt + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: memory requests and completions are
// queued as stimulus is driven and checked when the DUT produces them.
module tb_mem_arbiter;

  typedef struct {
    bit          is_if;
    logic [31:0] data;
    bit          err;
    bit          berr;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    bit          we;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid, stall_IF;
  logic [1:0]  wrn_MA = 2'b00;
  logic [2:0]  num_bytes_MA = 3'd0;
  logic        signado_MA = 1'b0;
  logic [31:0] addr_MA = '0;
  logic [31:0] wdata_MA = '0;
  logic [31:0] rdata_MA;
  logic        done_MA, err_MA, stall_MA, bus_err;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];
  req_t req_q[$];
  exp_t ce;
  req_t cr, cur;
  int          age = 0;
  int          ack_lat = 1;
  logic [31:0] rd_val = '0;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .stall_IF(stall_IF),
    .wrn_MA(wrn_MA), .num_bytes_MA(num_bytes_MA), .signado_MA(signado_MA),
    .addr_MA(addr_MA), .wdata_MA(wdata_MA), .rdata_MA(rdata_MA),
    .done_MA(done_MA), .err_MA(err_MA), .stall_MA(stall_MA),
    .mem(bus), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  end

  // Memory responder plus request/completion scoreboard, on the falling edge.
  always @(negedge clk) begin
    if (bus.mem_req) begin
      age = age + 1;
      if (age == 1) begin
        checks++;
        if (req_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_req addr=%h be=%b", bus.mem_addr, bus.mem_be);
        end else begin
          cr = req_q.pop_front();
          if ({bus.mem_addr, bus.mem_be, bus.mem_we} !== {cr.addr, cr.be, cr.we} ||
              (cr.we && bus.mem_wdata !== cr.wdata)) begin
            errors++;
            $display("FAIL req_fields got addr=%h be=%b we=%b wd=%h exp addr=%h be=%b we=%b wd=%h",
                     bus.mem_addr, bus.mem_be, bus.mem_we, bus.mem_wdata,
                     cr.addr, cr.be, cr.we, cr.wdata);
          end
        end
        cur.addr = bus.mem_addr; cur.be = bus.mem_be;
        cur.we = bus.mem_we; cur.wdata = bus.mem_wdata;
      end else begin
        checks++;
        if ({bus.mem_addr, bus.mem_be, bus.mem_we, bus.mem_wdata} !==
            {cur.addr, cur.be, cur.we, cur.wdata}) begin
          errors++;
          $display("FAIL req_stable got addr=%h be=%b exp addr=%h be=%b",
                   bus.mem_addr, bus.mem_be, cur.addr, cur.be);
        end
      end
      bus.mem_ack   = (ack_lat > 0) && (age >= ack_lat);
      bus.mem_rdata = rd_val;
    end else begin
      age = 0;
      bus.mem_ack = 1'b0;
    end

    if (if_valid || done_MA) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_completion if_valid=%b done_MA=%b", if_valid, done_MA);
      end else begin
        ce = exp_q.pop_front();
        if ({if_valid, done_MA} !== {ce.is_if, !ce.is_if}) begin
          errors++;
          $display("FAIL completion_owner got if_valid=%b done_MA=%b exp is_if=%b",
                   if_valid, done_MA, ce.is_if);
        end
        if ((ce.is_if ? if_rdata : rdata_MA) !== ce.data) begin
          errors++;
          $display("FAIL completion_data got %h exp %h", ce.is_if ? if_rdata : rdata_MA, ce.data);
        end
        if ({err_MA, bus_err} !== {ce.err, ce.berr}) begin
          errors++;
          $display("FAIL completion_err got err=%b berr=%b exp err=%b berr=%b",
                   err_MA, bus_err, ce.err, ce.berr);
        end
      end
    end
  end

  task automatic push_exp(input bit is_if, input logic [31:0] d, input bit e, input bit b);
    exp_t x;
    x.is_if = is_if; x.data = d; x.err = e; x.berr = b;
    exp_q.push_back(x);
  endtask

  task automatic push_req(input logic [31:0] a, input logic [3:0] be, input bit we,
                          input logic [31:0] wd);
    req_t x;
    x.addr = a; x.be = be; x.we = we; x.wdata = wd;
    req_q.push_back(x);
  endtask

  // Drives one MA operation, scrambles inputs after grant, waits for done_MA.
  task automatic ma_run(input logic [1:0] w, input logic [2:0] nb, input logic s,
                        input logic [31:0] a, input logic [31:0] d);
    bit seen = 0;
    @(negedge clk);
    wrn_MA = w; num_bytes_MA = nb; signado_MA = s; addr_MA = a; wdata_MA = d;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done_MA) seen = 1;
      else if (bus.mem_req) begin
        addr_MA = ~a; wdata_MA = ~d; signado_MA = ~s;
      end
    end
    wrn_MA = 2'b00;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL ma_wait got no done_MA exp done_MA within 40 cycles");
    end
    repeat (2) @(negedge clk);
  endtask

  // Holds both requesters until each has completed n transactions.
  task automatic run_both(input int n);
    int ma_done = 0;
    int if_done = 0;
    @(negedge clk);
    wrn_MA = 2'b01; num_bytes_MA = 3'd4; signado_MA = 1'b0; addr_MA = 32'h300;
    if_req = 1'b1; if_addr = 32'h400;
    for (int i = 0; i < 80 && (ma_done < n || if_done < n); i++) begin
      @(negedge clk);
      if (done_MA) ma_done++;
      if (if_valid) if_done++;
      if (ma_done >= n) wrn_MA = 2'b00;
      if (if_done >= n) if_req = 1'b0;
    end
    wrn_MA = 2'b00; if_req = 1'b0;
    checks++;
    if (ma_done != n || if_done != n) begin
      errors++;
      $display("FAIL arb_wait got ma=%0d if=%0d exp %0d each", ma_done, if_done, n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_be, if_valid, done_MA, err_MA, bus_err} !== 10'd0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 0",
               {bus.mem_req, bus.mem_we, bus.mem_be, if_valid, done_MA, err_MA, bus_err});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, if_rdata, rdata_MA} !== 128'd0) begin
      errors++;
      $display("FAIL reset_data got addr=%h wd=%h ifr=%h mar=%h exp 0",
               bus.mem_addr, bus.mem_wdata, if_rdata, rdata_MA);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_if_read;
    ack_lat = 1; rd_val = 32'hDEADBEEF;
    push_req(32'h104, 4'b1111, 0, '0);
    push_exp(1, 32'hDEADBEEF, 0, 0);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h104;
    #1;
    checks++;
    if (stall_IF !== 1'b1) begin
      errors++;
      $display("FAIL stall_IF got %b exp 1", stall_IF);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.mem_req !== 1'b1) begin
      errors++;
      $display("FAIL if_req_latency got mem_req=%b exp 1", bus.mem_req);
    end
    @(posedge clk); #1;
    checks++;
    if (if_valid !== 1'b1) begin
      errors++;
      $display("FAIL if_latency got if_valid=%b exp 1", if_valid);
    end
    if_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_ma_loads;
    ack_lat = 1; rd_val = 32'h80112233;
    push_req(32'h200, 4'b1000, 0, '0); push_exp(0, 32'hFFFFFF80, 0, 0);
    ma_run(2'b01, 3'd0, 1'b1, 32'h203, '0);
    push_req(32'h200, 4'b1000, 0, '0); push_exp(0, 32'h00000080, 0, 0);
    ma_run(2'b01, 3'd0, 1'b0, 32'h203, '0);
    push_req(32'h200, 4'b0010, 0, '0); push_exp(0, 32'h00000022, 0, 0);
    ma_run(2'b01, 3'd0, 1'b1, 32'h201, '0);
    push_req(32'h200, 4'b1100, 0, '0); push_exp(0, 32'hFFFF8011, 0, 0);
    ma_run(2'b01, 3'd2, 1'b1, 32'h202, '0);
    push_req(32'h200, 4'b0011, 0, '0); push_exp(0, 32'h00002233, 0, 0);
    ma_run(2'b01, 3'd2, 1'b1, 32'h200, '0);
    push_req(32'h200, 4'b1111, 0, '0); push_exp(0, 32'h80112233, 0, 0);
    ma_run(2'b01, 3'd4, 1'b1, 32'h200, '0);
  endtask

  task automatic test_ma_stores;
    ack_lat = 2; rd_val = 32'h55555555;
    push_req(32'h100, 4'b1100, 1, 32'hABCDABCD); push_exp(0, 32'h0, 0, 0);
    ma_run(2'b10, 3'd2, 1'b0, 32'h102, 32'h0000ABCD);
    push_req(32'h100, 4'b0010, 1, 32'h5A5A5A5A); push_exp(0, 32'h0, 0, 0);
    ma_run(2'b10, 3'd0, 1'b0, 32'h101, 32'h1234565A);
    push_req(32'h108, 4'b1111, 1, 32'hCAFEF00D); push_exp(0, 32'h0, 0, 0);
    ma_run(2'b10, 3'd4, 1'b0, 32'h108, 32'hCAFEF00D);
  endtask

  task automatic test_arbitration;
    test_reset();
    ack_lat = 1; rd_val = 32'h12345678;
    push_req(32'h300, 4'b1111, 0, '0); push_exp(0, 32'h12345678, 0, 0);
    push_req(32'h400, 4'b1111, 0, '0); push_exp(1, 32'h12345678, 0, 0);
    push_req(32'h300, 4'b1111, 0, '0); push_exp(0, 32'h12345678, 0, 0);
    push_req(32'h400, 4'b1111, 0, '0); push_exp(1, 32'h12345678, 0, 0);
    run_both(2);
    // Last grant MA: a simultaneous request from idle must go to IF first.
    push_req(32'h300, 4'b1111, 0, '0); push_exp(0, 32'h12345678, 0, 0);
    ma_run(2'b01, 3'd4, 1'b0, 32'h300, '0);
    push_req(32'h400, 4'b1111, 0, '0); push_exp(1, 32'h12345678, 0, 0);
    push_req(32'h300, 4'b1111, 0, '0); push_exp(0, 32'h12345678, 0, 0);
    run_both(1);
  endtask

  task automatic test_misaligned;
    push_exp(0, 32'h0, 1, 0);
    @(negedge clk);
    wrn_MA = 2'b01; num_bytes_MA = 3'd4; signado_MA = 1'b0; addr_MA = 32'h101;
    #1;
    checks++;
    if ({stall_MA, stall_IF} !== 2'b10) begin
      errors++;
      $display("FAIL stall_MA got %b%b exp 10", stall_MA, stall_IF);
    end
    @(posedge clk); #1;
    checks++;
    if ({done_MA, err_MA, bus.mem_req} !== 3'b110) begin
      errors++;
      $display("FAIL misalign_pulse got done/err/req=%b exp 110", {done_MA, err_MA, bus.mem_req});
    end
    @(negedge clk);
    wrn_MA = 2'b00;
    repeat (2) @(negedge clk);
    push_exp(0, 32'h0, 1, 0);
    ma_run(2'b10, 3'd2, 1'b0, 32'h203, 32'h1111);
    push_exp(0, 32'h0, 1, 0);
    ma_run(2'b01, 3'd3, 1'b0, 32'h200, '0);
  endtask

  task automatic test_timeout;
    int req_cycles = 0;
    bit seen = 0;
    ack_lat = 0; rd_val = 32'h77777777;
    push_req(32'h300, 4'b1111, 0, '0); push_exp(0, 32'h0, 0, 1);
    @(negedge clk);
    wrn_MA = 2'b01; num_bytes_MA = 3'd4; addr_MA = 32'h300;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_req) req_cycles++;
      if (done_MA) seen = 1;
    end
    wrn_MA = 2'b00;
    checks++;
    if (!seen || req_cycles != 4) begin
      errors++;
      $display("FAIL timeout_len got seen=%b req_cycles=%0d exp 1 and 4", seen, req_cycles);
    end
    repeat (2) @(negedge clk);
    ack_lat = 4; rd_val = 32'hCAFEF00D;
    push_req(32'h300, 4'b1111, 0, '0); push_exp(0, 32'hCAFEF00D, 0, 0);
    ma_run(2'b01, 3'd4, 1'b0, 32'h300, '0);
  endtask

  task automatic test_reset_mid;
    bit seen = 0;
    ack_lat = 0;
    push_req(32'h500, 4'b1111, 0, '0);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h500;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_req) seen = 1;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (!seen || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got seen=%b mem_req=%b exp 1 and 0", seen, bus.mem_req);
    end
    if_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ack_lat = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.mem_req, bus.mem_be, if_valid, done_MA, err_MA, bus_err, if_rdata, rdata_MA} !== 73'd0) begin
      errors++;
      $display("FAIL post_reset got req=%b be=%b ifr=%h mar=%h exp 0",
               bus.mem_req, bus.mem_be, if_rdata, rdata_MA);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish exp finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_if_read();
    test_ma_loads();
    test_ma_stores();
    test_arbitration();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0 || req_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained got exp=%0d req=%0d exp 0 0", exp_q.size(), req_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
